// File: rtl/pll_reset_sequencer_if.sv
// Avalon-MM style register bus shared by the PLL block and its reset sequencer.
// Same 3-bit address / 16-bit data layout as the PLL wrapper.
interface pll_reset_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Holds system resets while the PLL requests reset, then releases NUM_STAGES
// reset outputs in order with a programmable cycle gap between stages.
module pll_reset_sequencer #(
  parameter int NUM_STAGES          = 3,
  parameter int STAGE_DELAY_DEFAULT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  resetrequest_in,
  pll_reset_sequencer_if.slave  bus,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  all_released
);

  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           delay_q, delay_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  rel_q, rel_d;
  logic                  sw_pulse_q, sw_pulse_d;
  logic                  wr_en;
  logic                  hold_cond;
  logic                  unused_read;

  // readdata is a pure function of address, so the read strobe is not needed
  assign unused_read = bus.read;

  assign wr_en     = bus.chipselect & bus.write;
  assign hold_cond = resetrequest_in | sw_pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HOLD;
      idx_q      <= '0;
      cnt_q      <= '0;
      delay_q    <= 16'(STAGE_DELAY_DEFAULT);
      rst_q      <= '1;
      rel_q      <= 1'b0;
      sw_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      delay_q    <= delay_d;
      rst_q      <= rst_d;
      rel_q      <= rel_d;
      sw_pulse_q <= sw_pulse_d;
    end
  end

  always_comb begin
    sw_pulse_d = wr_en && (bus.address == 3'd1) && bus.writedata[0];
    delay_d    = delay_q;
    if (wr_en && (bus.address == 3'd2)) begin
      delay_d = bus.writedata;
    end
  end

  // Reloads read delay_q, so a delay write landing on a reload edge applies one stage later
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    rel_d   = rel_q;
    unique case (state_q)
      HOLD: begin
        rst_d = '1;
        rel_d = 1'b0;
        idx_d = '0;
        if (!hold_cond) begin
          state_d = RUN;
          cnt_d   = delay_q;
        end
      end
      RUN: begin
        if (hold_cond) begin
          state_d = HOLD;
          rst_d   = '1;
          rel_d   = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == 16'd0) begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == 3'(i)) rst_d[i] = 1'b0;
          end
          if (idx_q == 3'(NUM_STAGES - 1)) begin
            state_d = DONE;
            rel_d   = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = delay_q;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DONE: begin
        rst_d = '0;
        rel_d = 1'b1;
        if (hold_cond) begin
          state_d = HOLD;
          rst_d   = '1;
          rel_d   = 1'b0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = HOLD;
        rst_d   = '1;
        rel_d   = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    unique case (bus.address)
      3'd0:    bus.readdata = {10'd0, resetrequest_in, idx_q, (state_q == HOLD), rel_q};
      3'd2:    bus.readdata = delay_q;
      default: bus.readdata = 16'h0000;
    endcase
  end

  assign rst_out      = rst_q;
  assign all_released = rel_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: stage release timing, register map,
// software reset, mid-run restart, delay reload ordering and synchronous reset.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       resetrequest_in;
  logic [2:0] rst_out;
  logic       all_released;
  int         passed;
  int         total;

  pll_reset_sequencer_if bus_if ();

  pll_reset_sequencer #(
    .NUM_STAGES          (3),
    .STAGE_DELAY_DEFAULT (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .resetrequest_in (resetrequest_in),
    .bus             (bus_if),
    .rst_out         (rst_out),
    .all_released    (all_released)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_edges(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-14s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write      = 1'b1;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
    bus_if.writedata  = 16'h0000;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    #1;
    check(tag, bus_if.readdata, exp);
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset = 1'b1;
    resetrequest_in = 1'b1;
    bus_if.address = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.read = 1'b0;
    bus_if.write = 1'b0;
    bus_if.writedata = 16'h0000;

    // Reset state
    wait_edges(2);
    check("rst_rst_out", 16'(rst_out), 16'h0007);
    check("rst_released", 16'(all_released), 16'h0000);
    read_check("rst_delay", 3'd2, 16'h0010);
    read_check("rst_status", 3'd0, 16'h0022);
    reset = 1'b0;

    // Default delay 16: stages at edges 18, 35, 52
    wait_edges(10);
    check("hold_rst_out", 16'(rst_out), 16'h0007);
    resetrequest_in = 1'b0;
    tick();
    wait_edges(16);
    check("d16_e17", 16'(rst_out), 16'h0007);
    tick();
    check("d16_e18", 16'(rst_out), 16'h0006);
    wait_edges(16);
    check("d16_e34", 16'(rst_out), 16'h0006);
    tick();
    check("d16_e35", 16'(rst_out), 16'h0004);
    wait_edges(16);
    check("d16_e51_rel", 16'(all_released), 16'h0000);
    tick();
    check("d16_e52", 16'(rst_out), 16'h0000);
    check("d16_e52_rel", 16'(all_released), 16'h0001);
    read_check("done_status", 3'd0, 16'h0009);

    // Delay 2 written while held: stages at edges 4, 7, 10
    resetrequest_in = 1'b1;
    tick();
    check("rehold", 16'(rst_out), 16'h0007);
    bus_write(3'd2, 16'h0002);
    read_check("delay2_rb", 3'd2, 16'h0002);
    resetrequest_in = 1'b0;
    tick();
    wait_edges(2);
    check("d2_e3", 16'(rst_out), 16'h0007);
    tick();
    check("d2_e4", 16'(rst_out), 16'h0006);
    wait_edges(3);
    check("d2_e7", 16'(rst_out), 16'h0004);
    wait_edges(3);
    check("d2_e10", 16'(rst_out), 16'h0000);
    check("d2_e10_rel", 16'(all_released), 16'h0001);

    // Software reset from DONE
    bus_write(3'd1, 16'h0001);
    check("sw_wr_edge", 16'(rst_out), 16'h0000);
    tick();
    check("sw_hold", 16'(rst_out), 16'h0007);
    read_check("sw_status", 3'd0, 16'h0002);
    tick();
    wait_edges(2);
    check("sw_e3", 16'(rst_out), 16'h0007);
    tick();
    check("sw_e4", 16'(rst_out), 16'h0006);

    // One-cycle resetrequest glitch mid-run restarts from stage 0
    resetrequest_in = 1'b1;
    tick();
    check("glitch_hold", 16'(rst_out), 16'h0007);
    read_check("glitch_status", 3'd0, 16'h0022);
    resetrequest_in = 1'b0;
    tick();
    wait_edges(2);
    check("glitch_e3", 16'(rst_out), 16'h0007);
    tick();
    check("glitch_e4", 16'(rst_out), 16'h0006);

    // D=3, then write 5 on the stage-0 reload edge: gaps 4 then 6
    resetrequest_in = 1'b1;
    tick();
    bus_write(3'd2, 16'h0003);
    resetrequest_in = 1'b0;
    tick();
    wait_edges(3);
    check("d3_e4", 16'(rst_out), 16'h0007);
    bus_write(3'd2, 16'h0005);
    check("d3_e5", 16'(rst_out), 16'h0006);
    wait_edges(3);
    check("d3_e8", 16'(rst_out), 16'h0006);
    tick();
    check("d3_e9", 16'(rst_out), 16'h0004);
    wait_edges(5);
    check("d5_e14", 16'(rst_out), 16'h0004);
    tick();
    check("d5_e15", 16'(rst_out), 16'h0000);
    read_check("delay5_rb", 3'd2, 16'h0005);

    // Read-only / unmapped addresses
    bus_write(3'd0, 16'hFFFF);
    read_check("status_ro", 3'd0, 16'h0009);
    read_check("ctrl_rd0", 3'd1, 16'h0000);
    read_check("addr5_rd0", 3'd5, 16'h0000);

    // Synchronous reset mid-run
    resetrequest_in = 1'b1;
    tick();
    resetrequest_in = 1'b0;
    tick();
    wait_edges(5);
    check("d5r_e6", 16'(rst_out), 16'h0007);
    tick();
    check("d5r_e7", 16'(rst_out), 16'h0006);
    reset = 1'b1;
    tick();
    check("midrst_rst_out", 16'(rst_out), 16'h0007);
    check("midrst_rel", 16'(all_released), 16'h0000);
    read_check("midrst_delay", 3'd2, 16'h0010);
    read_check("midrst_status", 3'd0, 16'h0002);
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
